// File: rtl/prga_prog_serializer.sv
// prga_prog_serializer
//   Converts a stream of bitstream words into the serial prog_we/prog_din
//   interface of a PRGA fabric configuration chain. Each accepted word is
//   shifted out MSB first, one bit per clock. Consecutive words stream with no
//   gap when the next word is ready during the last bit of the previous one.
//   After the word flagged with s_last, the chain is left idle for
//   DRAIN_CYCLES clocks and then prog_done is raised.
//
//   Optional feature: define PRGA_PROG_CRC_EN to compute a CRC-16-CCITT
//   (poly 0x1021, init 0xFFFF, MSB first, no final XOR) over the emitted bits.
//   With crc_ok asserted in DONE when the CRC equals crc_expected. Without the
//   macro, crc_value is tied to 0, crc_ok to 1, and crc_expected is ignored.
//
// Ports
//   prog_clk      clock
//   prog_rst_n    synchronous active-low reset
//   start         one-cycle pulse starting a session (accepted in IDLE/DONE)
//   s_valid/s_ready/s_data/s_last   word stream (valid/ready handshake)
//   prog_we       high for every cycle carrying a valid bit
//   prog_din      serial bit (don't-care while prog_we is low)
//   prog_done     session complete; held until reset or start
//   busy          high in RUN, SHIFT and DRAIN
//   bit_cnt       bits emitted this session, saturating
//   crc_expected  reference CRC for the session
//   crc_value     running CRC of the emitted bits
//   crc_ok        CRC match flag
module prga_prog_serializer #(
    parameter int WORD_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 24
) (
    input  logic                  prog_clk,
    input  logic                  prog_rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  prog_we,
    output logic                  prog_din,
    output logic                  prog_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  bit_cnt,
    input  logic [15:0]           crc_expected,
    output logic [15:0]           crc_value,
    output logic                  crc_ok
);

    localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [IDX_W-1:0] REM_LOAD   = IDX_W'(WORD_WIDTH - 1);
    localparam logic [7:0]       DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t                 state;
    state_t                 state_nxt;
    logic [WORD_WIDTH-1:0]  shreg;
    logic [WORD_WIDTH-1:0]  shreg_nxt;
    // Number of bits of the current word still to come after the one on prog_din.
    logic [IDX_W-1:0]       rem;
    logic [IDX_W-1:0]       rem_nxt;
    logic                   last_word;
    logic                   last_nxt;
    logic [7:0]             drain_cnt;
    logic [7:0]             drain_nxt;
    logic                   s_ready_nxt;
    logic                   prog_we_nxt;
    logic                   prog_din_nxt;
    logic [CNT_WIDTH-1:0]   bit_cnt_nxt;
    logic                   load_word;
    logic                   clear;
    logic                   accept;

    assign accept = s_valid && s_ready;

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        rem_nxt      = rem;
        last_nxt     = last_word;
        drain_nxt    = drain_cnt;
        s_ready_nxt  = 1'b0;
        prog_we_nxt  = 1'b0;
        prog_din_nxt = prog_din;
        bit_cnt_nxt  = bit_cnt;
        load_word    = 1'b0;
        clear        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    s_ready_nxt = 1'b1;
                    clear       = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    load_word = 1'b1;
                end else begin
                    s_ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (rem != '0) begin
                    prog_we_nxt  = 1'b1;
                    prog_din_nxt = shreg[WORD_WIDTH-1];
                    shreg_nxt    = shreg << 1;
                    rem_nxt      = rem - IDX_W'(1);
                    // Open the handshake while the final bit is on the wire so a
                    // waiting word follows without a bubble.
                    s_ready_nxt  = (rem == IDX_W'(1)) && !last_word;
                end else if (last_word) begin
                    state_nxt = DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end else if (accept) begin
                    load_word = 1'b1;
                end else begin
                    state_nxt   = RUN;
                    s_ready_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 8'd0) begin
                    state_nxt = DONE;
                end else begin
                    drain_nxt = drain_cnt - 8'd1;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt   = RUN;
                    s_ready_nxt = 1'b1;
                    clear       = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // First bit of a new word goes out on the same edge that accepts it.
        if (load_word) begin
            state_nxt    = SHIFT;
            prog_we_nxt  = 1'b1;
            prog_din_nxt = s_data[WORD_WIDTH-1];
            shreg_nxt    = s_data << 1;
            rem_nxt      = REM_LOAD;
            last_nxt     = s_last;
            s_ready_nxt  = (WORD_WIDTH == 1) && !s_last;
        end

        if (clear) begin
            bit_cnt_nxt = '0;
        end
        if (prog_we_nxt) begin
            bit_cnt_nxt = sat_inc(bit_cnt);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            last_word <= 1'b0;
            drain_cnt <= 8'd0;
            s_ready   <= 1'b0;
            prog_we   <= 1'b0;
            prog_din  <= 1'b0;
            prog_done <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            last_word <= last_nxt;
            drain_cnt <= drain_nxt;
            s_ready   <= s_ready_nxt;
            prog_we   <= prog_we_nxt;
            prog_din  <= prog_din_nxt;
            prog_done <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE) && (state_nxt != DONE);
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    // Shift register holds payload only; a reset abandons it by leaving SHIFT.
    always_ff @(posedge prog_clk) begin
        shreg <= shreg_nxt;
    end

`ifdef PRGA_PROG_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    logic [15:0] crc_nxt;

    always_comb begin
        crc_nxt = crc_value;
        if (clear) begin
            crc_nxt = 16'hFFFF;
        end
        if (prog_we_nxt) begin
            crc_nxt = crc_step(crc_value, prog_din_nxt);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            crc_value <= 16'hFFFF;
            crc_ok    <= 1'b0;
        end else begin
            crc_value <= crc_nxt;
            crc_ok    <= (state_nxt == DONE) && (crc_nxt == crc_expected);
        end
    end
`else
    logic unused_crc_expected;

    assign unused_crc_expected = ^crc_expected;
    assign crc_value           = 16'h0000;
    assign crc_ok              = 1'b1;
`endif

endmodule

// File: doc/prga_prog_serializer.md
PRGA_PROG_SERIALIZER -- requirements
Module: prga_prog_serializer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: width in bits of each bitstream word.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: number of idle cycles between the final bit and prog_done; legal range 1..255.
REQ-003 SHALL have parameter CNT_WIDTH, default 24: width of the bit counter.
REQ-004 SHALL have port prog_clk, input, 1: the single clock.
REQ-005 SHALL have port prog_rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that begins a programming session.
REQ-007 SHALL have port s_valid, input, 1: word-stream valid.
REQ-008 SHALL have port s_ready, output, 1: word-stream ready.
REQ-009 SHALL have port s_data, input, WORD_WIDTH: bitstream word, shifted out MSB first.
REQ-010 SHALL have port s_last, input, 1: marks the final word of the session.
REQ-011 SHALL have port prog_we, output, 1: fabric write enable, high once per valid bit.
REQ-012 SHALL have port prog_din, output, 1: fabric serial data.
REQ-013 SHALL have port prog_done, output, 1: programming complete.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE or DONE.
REQ-015 SHALL have port bit_cnt, output, CNT_WIDTH: number of bits emitted in the current session.
REQ-016 SHALL have port crc_expected, input, 16: reference CRC for the session.
REQ-017 SHALL have port crc_value, output, 16: running CRC of the emitted bits.
REQ-018 SHALL have port crc_ok, output, 1: CRC match flag.

Function
REQ-019 SHALL implement states IDLE, RUN, SHIFT, DRAIN and DONE.
REQ-020 SHALL go IDLE->RUN on start; start SHALL be ignored in RUN, SHIFT and DRAIN.
REQ-021 SHALL hold s_ready low in IDLE, DRAIN and DONE, so a word presented with start in IDLE is not accepted that cycle.
REQ-022 SHALL accept a word when s_valid and s_ready are both high at a prog_clk edge; RUN with s_ready high is the only accepting wait state.
REQ-023 SHALL, for a word accepted at edge N, drive prog_we=1 with prog_din=s_data[W-1-k] in cycle N+1+k, for k=0..W-1; all outputs registered.
REQ-024 SHALL assert s_ready during the last-bit cycle of a non-last word, so a word available then streams with zero bubble.
REQ-025 SHALL, if no word is accepted in the last-bit cycle, return to RUN and drive prog_we=0 (bubble) until a word is accepted; prog_din is don't-care while prog_we=0.
REQ-026 SHALL, after the last bit of an s_last word, enter DRAIN with prog_we=0 for exactly DRAIN_CYCLES cycles, then enter DONE with prog_done=1.
REQ-027 SHALL hold prog_done high in DONE until reset or start; start in DONE SHALL clear prog_done, bit_cnt and the CRC and enter RUN on the next cycle.
REQ-028 SHALL increment bit_cnt on each prog_we=1 cycle, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-029 SHALL keep bit_cnt at its final value in DONE.

Reset
REQ-030 SHALL, when prog_rst_n=0 at a clock edge, in any state and including mid-word, enter IDLE and discard the shift register contents.
REQ-031 SHALL produce the reset values s_ready=0, prog_we=0, prog_din=0, prog_done=0, busy=0, bit_cnt=0, crc_value=16'hFFFF (16'h0000 without the macro) and crc_ok=0 (1 without the macro).

Configuration
REQ-032 SHALL, with PRGA_PROG_CRC_EN defined, update crc_value for each emitted bit as CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final XOR).
REQ-033 SHALL, with PRGA_PROG_CRC_EN defined, set crc_ok in DONE to (crc_value==crc_expected) and hold crc_ok=0 outside DONE.
REQ-034 SHALL, without PRGA_PROG_CRC_EN, keep all ports present, tie crc_value=0 and crc_ok=1, ignore crc_expected, and contain no CRC logic.

Verification
REQ-035 SHALL cover: start; one word 32'hA5A5_0001 with s_last -> 32 consecutive prog_we cycles carrying bits 1,0,1,0,0,1,0,1,...,1 in order, 4 idle cycles, then prog_done=1 and bit_cnt=32.
REQ-036 SHALL cover: three back-to-back words with s_valid held high -> 96 contiguous prog_we cycles and s_ready high only in bit-31 cycles.
REQ-037 SHALL cover: s_valid dropped for 5 cycles between words -> exactly 5 prog_we=0 bubble cycles and no lost or duplicated bits.
REQ-038 SHALL cover: prog_rst_n=0 at bit 10 of a word -> IDLE next cycle with all outputs at reset values, and a subsequent start with 1 word -> bit_cnt=32.
REQ-039 SHALL cover, with PRGA_PROG_CRC_EN: the single byte-aligned word 32'h3132_3334 ("1234") and a matching crc_expected -> crc_ok=1 in DONE, and crc_expected off by one bit -> crc_ok=0.
REQ-040 SHALL cover: start asserted in DONE -> prog_done=0, bit_cnt=0 next cycle, and a new session completes normally.
